// File: rtl/load_scoreboard.sv
// Decode-stage scoreboard for variable-latency loads.
// Tracks pending load destinations and stalls dependent or excess loads.
module load_scoreboard #(
  parameter int MAX_LOADS = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_flush,
  input  logic             id_memRead,
  input  logic             id_regWrite,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             wb_load_done,
  input  logic [4:0]       wb_rd,
  output logic             stall,
  output logic             load_issue,
  output logic [31:0]      pending,
  output logic [3:0]       outstanding,
  output logic             full,
  output logic [CNT_W-1:0] stall_cycles
);

  logic        raw1;
  logic        raw2;
  logic        cap;
  logic        is_load;
  logic [31:0] pend_d;
  logic [3:0]  out_d;

  assign is_load = id_memRead & id_regWrite;
  assign full    = (outstanding == 4'(MAX_LOADS));

  // A register retiring this cycle is covered by the WB bypass.
  assign raw1 = id_use_rs1 & (id_rs1 != 5'd0)
              & pending[id_rs1]
              & ~(wb_load_done & (wb_rd == id_rs1));
  assign raw2 = id_use_rs2 & (id_rs2 != 5'd0)
              & pending[id_rs2]
              & ~(wb_load_done & (wb_rd == id_rs2));

  // A completion in the same cycle frees a slot.
  assign cap = is_load & full & ~wb_load_done;

  assign stall = ~rst & id_valid & ~id_flush
               & (raw1 | raw2 | cap);

  assign load_issue = id_valid & ~id_flush & ~stall
                    & is_load & (id_rd != 5'd0);

  always_comb begin
    pend_d = pending;
    if (wb_load_done)
      pend_d[wb_rd] = 1'b0;
    if (load_issue)
      pend_d[id_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Completion with nothing in flight saturates at zero.
  always_comb begin
    out_d = outstanding;
    unique case (1'b1)
      (load_issue & ~wb_load_done):
        out_d = outstanding + 4'd1;
      (wb_load_done & ~load_issue
        & (outstanding != 4'd0)):
        out_d = outstanding - 4'd1;
      default:
        out_d = outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= '0;
      outstanding  <= '0;
      stall_cycles <= '0;
    end else begin
      pending      <= pend_d;
      outstanding  <= out_d;
      stall_cycles <= stall_cycles + CNT_W'(stall);
    end
  end

endmodule

// File: tb/tb_load_scoreboard.sv
// Bench for load_scoreboard: directed plan steps plus random traffic
// checked against a register-busy-table reference model.
module tb_load_scoreboard;

  localparam int MAXL = 4;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_flush;
  logic          id_memRead, id_regWrite;
  logic [4:0]    id_rd, id_rs1, id_rs2;
  logic          id_use_rs1, id_use_rs2;
  logic          wb_load_done;
  logic [4:0]    wb_rd;
  logic          stall, load_issue, full;
  logic [31:0]   pending;
  logic [3:0]    outstanding;
  logic [CW-1:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  bit busy [32];
  int in_flight;
  int n_stalls;

  load_scoreboard #(.MAX_LOADS(MAXL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_flush(id_flush),
    .id_memRead(id_memRead), .id_regWrite(id_regWrite),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .wb_load_done(wb_load_done), .wb_rd(wb_rd),
    .stall(stall), .load_issue(load_issue),
    .pending(pending), .outstanding(outstanding),
    .full(full), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: got %0h expected %0h",
             tag, $time, obs, exp);
    end
  endtask

  function automatic bit hazard(input logic u,
                                input logic [4:0] r,
                                input logic d,
                                input logic [4:0] w);
    return u && r != 0 && busy[r] && !(d && w == r);
  endfunction

  task automatic cycle(input logic r, v, f, mr, rw,
                       input logic [4:0] rd, rs1, rs2,
                       input logic u1, u2, d,
                       input logic [4:0] w);
    bit          e_full, e_stall, e_issue;
    logic [31:0] e_pend;
    rst = r; id_valid = v; id_flush = f;
    id_memRead = mr; id_regWrite = rw;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2;
    wb_load_done = d; wb_rd = w;
    @(negedge clk);
    e_full  = (in_flight == MAXL);
    e_stall = !r && v && !f &&
              (hazard(u1, rs1, d, w) || hazard(u2, rs2, d, w) ||
               (mr && rw && e_full && !d));
    e_issue = v && !f && !e_stall && mr && rw && rd != 0;
    for (int i = 0; i < 32; i++) e_pend[i] = busy[i];
    chk("stall", 64'(stall), 64'(e_stall));
    if (!r) chk("load_issue", 64'(load_issue), 64'(e_issue));
    chk("pending", 64'(pending), 64'(e_pend));
    chk("outstanding", 64'(outstanding), 64'(in_flight));
    chk("full", 64'(full), 64'(e_full));
    chk("stall_cycles", 64'(stall_cycles), 64'(n_stalls % (1 << CW)));
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) busy[i] = 0;
      in_flight = 0;
      n_stalls  = 0;
    end else begin
      if (d) busy[w] = 0;
      if (e_issue) busy[rd] = 1;
      busy[0] = 0;
      if (e_issue && !d) in_flight++;
      else if (d && !e_issue && in_flight > 0) in_flight--;
      if (e_stall) n_stalls++;
    end
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ld(input logic [4:0] rd,
                    input logic d, input logic [4:0] w);
    cycle(0, 1, 0, 1, 1, rd, 0, 0, 0, 0, d, w);
  endtask

  task automatic use1(input logic [4:0] rs, input logic f,
                      input logic d, input logic [4:0] w);
    cycle(0, 1, f, 0, 1, 5'd10, rs, 0, 1, 0, d, w);
  endtask

  task automatic done(input logic [4:0] w);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, w);
  endtask

  initial begin
    logic       r, v, f, mr, rw, u1, u2, d;
    logic [4:0] rd, rs1, rs2, w;
    for (int i = 0; i < 32; i++) busy[i] = 0;
    in_flight = 0;
    n_stalls  = 0;
    rst = 1'b1; id_valid = 0; id_flush = 0;
    id_memRead = 0; id_regWrite = 0;
    id_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_use_rs1 = 0; id_use_rs2 = 0;
    wb_load_done = 0; wb_rd = 0;
    @(posedge clk); #1;

    // reset then idle
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();

    // load x5, dependent add stalls until writeback
    ld(5, 0, 0);
    use1(5, 0, 0, 0);
    use1(5, 0, 0, 0);
    use1(5, 0, 0, 0);
    use1(5, 0, 1, 5);
    chk("p5_bypass_stall", 64'(stall), 64'(0));
    idle();
    chk("p5_cleared", 64'(pending[5]), 64'(0));

    // fill to MAX_LOADS, fifth load waits for a completion
    ld(1, 0, 0);
    ld(2, 0, 0);
    ld(3, 0, 0);
    ld(4, 0, 0);
    ld(6, 0, 0);
    ld(6, 0, 0);
    ld(6, 1, 1);
    chk("issue_at_full", 64'(load_issue), 64'(1));
    idle();
    chk("outstanding_4", 64'(outstanding), 64'(4));

    // drain, then same-cycle retire/issue of x7
    done(2);
    done(4);
    done(6);
    ld(7, 0, 0);
    ld(7, 1, 7);
    idle();
    chk("p7_set", 64'(pending[7]), 64'(1));

    // x0 is never tracked
    ld(0, 0, 0);
    use1(0, 0, 0, 0);
    cycle(0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0);

    // flush masks a real hazard on x3, then reset mid-flight
    use1(3, 1, 0, 0);
    use1(3, 0, 0, 0);
    cycle(1, 1, 0, 1, 1, 5'd8, 5'd3, 0, 1, 0, 0, 0);
    idle();

    // completion with nothing in flight saturates
    done(9);
    ld(11, 1, 11);
    idle();

    // long stall wraps the narrow counter
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ld(9, 0, 0);
    for (int i = 0; i < 300; i++)
      cycle(0, 1, 0, 0, 1, 5'd12, 0, 5'd9, 0, 1, 0, 0);
    done(9);
    idle();

    // random traffic over a small register window
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 63) == 0);
      v   = ($urandom_range(0, 3) != 0);
      f   = ($urandom_range(0, 7) == 0);
      mr  = ($urandom_range(0, 2) == 0);
      rw  = mr ? ($urandom_range(0, 7) != 0)
               : ($urandom_range(0, 1) == 1);
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      u1  = ($urandom_range(0, 1) == 1);
      u2  = ($urandom_range(0, 1) == 1);
      d   = ($urandom_range(0, 3) == 0);
      w   = 5'($urandom_range(0, 7));
      cycle(r, v, f, mr, rw, rd, rs1, rs2, u1, u2, d, w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_scoreboard.md
Name: load_scoreboard

Overview:
- Decode-stage hazard tracker for the RISC-V pipeline. It covers the producer-side counterpart of operand forwarding.
- Loads with variable data-memory latency cannot be forwarded until their data returns. This block records each outstanding load destination register in a pending vector.
- It stalls decode while a consumer reads a pending register, or while the outstanding-load limit is reached.
- It sits beside the ID stage. Outputs drive PC/IF-ID write enables and the ID/EX bubble mux.

Parameters:
- MAX_LOADS, 4, maximum outstanding loads in flight (1..15).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous active-high reset.
- id_valid  input  1  valid instruction in ID.
- id_flush  input  1  ID instruction squashed this cycle (branch/jump taken).
- id_memRead  input  1  ID instruction is a load.
- id_regWrite  input  1  ID instruction writes rd.
- id_rd  input  5  ID destination register.
- id_rs1  input  5  ID source 1.
- id_rs2  input  5  ID source 2.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- wb_load_done  input  1  load data written back this cycle.
- wb_rd  input  5  register written by the completing load.
- stall  output  1  hold PC and IF/ID, insert bubble into ID/EX.
- load_issue  output  1  load accepted into the pipeline this cycle.
- pending  output  32  registered pending-load vector, bit n = x(n) awaiting load data.
- outstanding  output  4  registered count of in-flight loads.
- full  output  1  outstanding == MAX_LOADS.
- stall_cycles  output  CNT_W  count of cycles with stall asserted.

Behaviour:
- Reset is synchronous, rst high at a clk edge. It sets pending=0, outstanding=0 and stall_cycles=0. It has priority over all other inputs, including mid-flight loads; in-flight loads are forgotten.
- Combinational hazard terms:
  - raw1 = id_use_rs1 & id_rs1!=0 & pending[id_rs1] & !(wb_load_done & wb_rd==id_rs1).
  - raw2 is the same expression using rs2.
  - A register being cleared this cycle is not a hazard, because the WB bypass covers it.
- Structural term: cap = id_memRead & id_regWrite & full & !wb_load_done.
- stall = id_valid & !id_flush & (raw1 | raw2 | cap). stall is 0 during rst.
- load_issue = id_valid & !id_flush & !stall & id_memRead & id_regWrite & id_rd!=0.
- A load with rd=0 is not tracked and does not count.
- Pending update at each clk edge:
  - Clear bit wb_rd when wb_load_done.
  - Then set bit id_rd when load_issue.
  - Set wins when both name the same register, because the issuing load is younger.
  - Bit 0 always stays 0.
- outstanding update:
  - +1 on load_issue only.
  - -1 on wb_load_done only.
  - Unchanged when both or neither occur.
- Boundary cases:
  - wb_load_done while outstanding==0 is a protocol error. The counter holds at 0 (saturate) and the pending bit is cleared anyway.
  - Overflow is impossible because cap blocks issue at full. Issue at full is allowed when a completion occurs in the same cycle.
- stall_cycles increments by 1 on each cycle with stall=1. It wraps modulo 2^CNT_W.
- Latency: stall and load_issue are combinational from inputs plus registered state. pending and outstanding reflect an event one cycle after it occurs.
- id_flush masks both stall and load_issue in the same cycle.
- A stalled instruction re-evaluates every cycle until its hazard clears. There is no timeout.

Test Plan:
- Reset then idle -> pending=0, outstanding=0, stall=0, stall_cycles=0.
- Issue load x5 (id_valid, memRead, regWrite, rd=5); next cycle ADD reads rs1=5 -> stall=1 each cycle until wb_load_done with wb_rd=5. In that cycle stall=0 and the next cycle has pending[5]=0.
- Issue 4 loads to x1..x4 (MAX_LOADS=4), then a 5th load to x6 -> full=1 and stall=1. The 5th is accepted in the cycle wb_load_done(x1) arrives, and outstanding stays 4.
- Same-cycle wb_load_done(x7) and load_issue(x7) -> pending[7]=1 and outstanding unchanged.
- Load with rd=0, and a consumer using rs1=0 -> load_issue=0, outstanding unchanged, stall=0.
- With pending[3]=1, a consumer of x3 is stalled and id_flush=1 -> stall=0, stall_cycles unchanged. Then rst=1 mid-flight -> pending=0, outstanding=0 next cycle.
